// File: rtl/async_adder_seq.sv
// ---------------------------------------------------------------------------
// async_adder_seq
//
// Clocked sequencer for an asynchronous ripple-carry adder. Operand pairs are
// buffered in a 2-entry FIFO, presented to the adder with a registered start
// level, and the adder's asynchronous completion is synchronised back into
// the clk domain. The sum (or a timeout error) is returned over valid/ready.
//
// Parameters:
//   WIDTH        operand / sum width, must match the adder
//   SYNC_STAGES  flops in the adder_done synchroniser (>= 2)
//   SETTLE       minimum cycles adder_start is high before sum is sampled (>= 1)
//   TIMEOUT      maximum start-high cycles before abort (> SETTLE + SYNC_STAGES)
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   in_valid     operand pair offered
//   in_ready     buffer not full
//   in_a, in_b   operands
//   adder_a/b    registered operands to the adder
//   adder_start  registered start level to the adder
//   adder_sum    adder result (asynchronous)
//   adder_done   adder completion (asynchronous)
//   out_valid    result available
//   out_ready    consumer accepts result
//   out_sum      captured sum (modulo 2^WIDTH), 0 on timeout
//   out_err      result aborted by timeout
// ---------------------------------------------------------------------------
module async_adder_seq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_start,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FIRE,
    S_WAIT,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  // -------------------------------------------------------------------------
  // Operand buffer: 2-entry FIFO of {a, b}
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] buf_a [2];
  logic [WIDTH-1:0] buf_b [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  // A pop only happens from IDLE with data present, so a pop never meets an
  // empty buffer and a push never meets a full one.
  assign pop      = (state == S_IDLE) && (count != 2'd0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count/pointers alone,
  // so stale entries are never observable and the array maps to plain flops
  // or RAM without reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_a[wr_ptr] <= in_a;
      buf_b[wr_ptr] <= in_b;
    end
  end

  // -------------------------------------------------------------------------
  // adder_done synchroniser
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_s;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], adder_done};
  end

  // done_s may still be high from the previous operation; it is only trusted
  // once the SETTLE minimum has elapsed in WAIT.
  assign done_s = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  // cnt counts cycles since adder_start rose: 0 in FIRE, 1 on the first WAIT
  // cycle, so WAIT lasts exactly SETTLE cycles when done_s is already high.
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             abort_q, abort_nxt;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    abort_nxt = abort_q;
    cnt_nxt   = cnt;

    unique case (state)
      S_IDLE: begin
        if (count != 2'd0) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        state_nxt = S_FIRE;
      end
      S_FIRE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if ((cnt >= SETTLE_C) && done_s) begin
          state_nxt = S_CAPTURE;
          abort_nxt = 1'b0;
        end else if (cnt == TIMEOUT_C) begin
          state_nxt = S_CAPTURE;
          abort_nxt = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (state_nxt == S_FIRE)      cnt_nxt = '0;
    else if (state_nxt == S_WAIT) cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      abort_q     <= 1'b0;
      adder_a     <= '0;
      adder_b     <= '0;
      adder_start <= 1'b0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      abort_q <= abort_nxt;

      // Operands change only on an IDLE pop, so they are stable from SETUP
      // through CAPTURE.
      if (pop) begin
        adder_a <= buf_a[rd_ptr];
        adder_b <= buf_b[rd_ptr];
      end

      // Start is high through FIRE, WAIT and CAPTURE: one rising edge per
      // operand pair, entered only from SETUP.
      adder_start <= (state_nxt inside {S_FIRE, S_WAIT, S_CAPTURE});

      if (state == S_CAPTURE) begin
        out_sum <= abort_q ? '0 : adder_sum;
        out_err <= abort_q;
      end

      out_valid <= (state_nxt == S_OUT);
    end
  end

endmodule

// File: tb/tb_async_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_async_adder_seq
//
// Directed bench for async_adder_seq with a behavioural asynchronous adder.
// Expected results are queued when a pair is accepted and compared when the
// DUT hands a result over. Covers reset, single add latency, wrap-around,
// back-pressure ordering, timeout, reset mid-operation and push/pop at
// occupancy 1 with random operands.
// ---------------------------------------------------------------------------
module tb_async_adder_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] adder_a;
  logic [W-1:0] adder_b;
  logic         adder_start;
  logic [W-1:0] adder_sum;
  logic         adder_done;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_err;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         err;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  async_adder_seq #(
    .WIDTH      (W),
    .SYNC_STAGES(2),
    .SETTLE     (2),
    .TIMEOUT    (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_start(adder_start),
    .adder_sum  (adder_sum),
    .adder_done (adder_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_err    (out_err)
  );

  // Behavioural adder: sum settles a short delay after the operands change;
  // done is driven directly by the bench (stale-high by default).
  assign #2 adder_sum = adder_a + adder_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair and return 1 ns after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    res_t r;
    n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    r.sum = a + b;
    r.err = 1'b0;
    sb.push_back(r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Count start-high cycles and find the first out_valid after an accept.
  task automatic measure(input int cycles, output int first_valid, output int start_cnt);
    first_valid = 0;
    start_cnt   = 0;
    for (int k = 1; k <= cycles; k++) begin
      tick();
      if (adder_start) start_cnt++;
      if (out_valid && first_valid == 0) first_valid = k;
    end
  endtask

  // Result monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      res_t e;
      chk("result_expected", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_sum", {24'b0, out_sum}, {24'b0, e.sum});
        chk("out_err", {31'b0, out_err}, {31'b0, e.err});
      end
      n_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first_v;
    int   starts;
    int   k;
    int   n_before;
    logic seen;
    logic [W-1:0] pa, pb, ra, rb;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    adder_done = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",    {31'b0, in_ready},    1);
    chk("rst_adder_a",     {24'b0, adder_a},     0);
    chk("rst_adder_b",     {24'b0, adder_b},     0);
    chk("rst_adder_start", {31'b0, adder_start}, 0);
    chk("rst_out_valid",   {31'b0, out_valid},   0);
    chk("rst_out_sum",     {24'b0, out_sum},     0);
    chk("rst_out_err",     {31'b0, out_err},     0);
    rst = 1'b0;
    repeat (4) tick();

    // Single add: latency T+6, start high 4 cycles
    out_ready = 1'b1;
    send(8'h25, 8'h17);
    measure(9, first_v, starts);
    chk("single_latency", first_v, 6);
    chk("single_start_cycles", starts, 4);
    drain();

    // Wrap-around, back to back
    send(8'hFF, 8'h01);
    send(8'h80, 8'h80);
    drain();

    // Back-pressure: two buffered plus one in flight
    out_ready = 1'b0;
    send(8'd1, 8'd2);
    send(8'd3, 8'd4);
    send(8'd5, 8'd6);
    chk("bp_in_ready_low", {31'b0, in_ready}, 0);
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("bp_first_valid", {31'b0, out_valid}, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", {31'b0, out_valid}, 1);
      chk("bp_hold_sum", {24'b0, out_sum}, 32'h03);
      chk("bp_hold_ready", {31'b0, in_ready}, 0);
    end
    out_ready = 1'b1;
    drain();

    // Timeout: done held low
    adder_done = 1'b0;
    repeat (3) tick();
    send(8'h11, 8'h22);
    sb[sb.size()-1] = '{sum: 8'h00, err: 1'b1};
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("timeout_latency", k, 19);
    chk("timeout_err", {31'b0, out_err}, 1);
    chk("timeout_sum", {24'b0, out_sum}, 0);
    adder_done = 1'b1;
    drain();
    repeat (2) tick();
    send(8'h40, 8'h02);
    measure(9, first_v, starts);
    chk("post_timeout_latency", first_v, 6);
    drain();

    // Reset mid-WAIT flushes in-flight and buffered pairs
    send(8'h01, 8'h01);
    send(8'h02, 8'h02);
    tick();
    tick();
    chk("pre_rst_start", {31'b0, adder_start}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_adder_start", {31'b0, adder_start}, 0);
    chk("midrst_out_valid",   {31'b0, out_valid},   0);
    chk("midrst_in_ready",    {31'b0, in_ready},    1);
    sb.delete();
    n_before = n_out;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", {31'b0, seen}, 0);
    chk("flush_no_output", n_out, n_before);

    // Push/pop at occupancy 1 with random operands
    pa = 8'($urandom);
    pb = 8'($urandom);
    send(pa, pb);
    for (int i = 1; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i > 1) begin
        repeat (6) tick();
        chk("occ1_in_ready", {31'b0, in_ready}, 1);
      end
      send(ra, rb);
      chk("occ1_pop_a", {24'b0, adder_a}, {24'b0, pa});
      chk("occ1_pop_b", {24'b0, adder_b}, {24'b0, pb});
      chk("occ1_ready_after", {31'b0, in_ready}, 1);
      pa = ra;
      pb = rb;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_adder_seq.md
# async_adder_seq

Clocked sequencer that sits directly upstream of the asynchronous ripple-carry adder. It is also the adder's result consumer. It accepts operand pairs over a valid/ready interface into a 2-entry buffer. It drives the adder's operand and `start` inputs and synchronises the adder's `done` back into the clock domain. It captures `sum` and presents each result, with an error flag for timeouts, over a valid/ready output.

## Interface
- `WIDTH`, 8: operand and sum width; must match the adder.
- `SYNC_STAGES`, 2: flops in the `adder_done` synchroniser, ≥2.
- `SETTLE`, 2: minimum cycles `adder_start` is held high before `sum` may be sampled, ≥1.
- `TIMEOUT`, 15: maximum WAIT cycles before aborting, > `SETTLE` + `SYNC_STAGES`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  buffer can accept; = buffer not full.
- `in_a`, `in_b`  in  WIDTH  operands.
- `adder_a`, `adder_b`  out  WIDTH  registered operands to adder.
- `adder_start`  out  1  registered start pulse to adder.
- `adder_sum`  in  WIDTH  adder result (asynchronous).
- `adder_done`  in  1  adder completion (asynchronous).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  WIDTH  captured sum.
- `out_err`  out  1  result aborted by timeout; `out_sum` is 0.

## Operation
- Buffer: 2-entry FIFO of {a,b}.
  - Push on `in_valid & in_ready`; pop when FSM leaves IDLE.
  - Push and pop in the same cycle are allowed at occupancy 1.
  - Occupancy never exceeds 2; no overwrite.
- `adder_done` passes through a `SYNC_STAGES`-flop synchroniser to give `done_s`.
  - The adder's `done` can stay high from the previous operation.
  - `done_s` therefore counts only together with the `SETTLE` minimum.
- FSM states:
  - IDLE: `adder_start`=0. If the buffer is non-empty: pop, load `adder_a`/`adder_b`, go to SETUP.
  - SETUP: operands settle, `adder_start`=0. Go to FIRE.
  - FIRE: `adder_start`←1, `cnt`←0. Go to WAIT.
  - WAIT: `adder_start` stays 1; `cnt` increments each cycle.
    - If `cnt` ≥ `SETTLE` and `done_s`=1: go to CAPTURE.
    - Else if `cnt` = `TIMEOUT`: go to CAPTURE with the abort flag set.
  - CAPTURE: `out_sum`←`adder_sum` (0 on abort), `out_err`←abort, `out_valid`←1, `adder_start`←0. Go to OUT.
  - OUT: hold `out_valid`, `out_sum` and `out_err` stable until `out_ready`=1. On that edge `out_valid`←0; go to IDLE.
- `adder_a`/`adder_b` are stable from SETUP through CAPTURE and change only on an IDLE pop.
- `adder_start` rises only in FIRE, so the adder sees exactly one rising edge per operand pair.
- Width rule: the sum is WIDTH bits; carry-out is discarded (modulo 2^WIDTH).

## Timing
- Reset values: `in_ready`=1, `adder_a`=0, `adder_b`=0, `adder_start`=0, `out_valid`=0, `out_sum`=0, `out_err`=0. FSM goes to IDLE, buffer is emptied, `cnt`=0, synchroniser flops cleared.
- Reset mid-operation: on the reset edge all outputs take their reset values, including dropping `adder_start` and any held `out_valid`. In-flight and buffered operands are discarded.
- Latency from an accepting edge T into an empty buffer, with the FSM idle and `done_s` already high: `out_valid`=1 after the edge at T+4+`SETTLE` (T+6 with defaults).
  - If `done_s` is low, add `SYNC_STAGES` + the adder delay.
- Throughput: one result per 5+`SETTLE` cycles with `out_ready` tied high.
  - Back-to-back: IDLE pops on the cycle after the OUT handshake.
- `in_ready` deasserts the cycle after the second entry is written. It reasserts the cycle after a pop.
- Timeout: `out_valid` with `out_err`=1 after the edge at T+4+`TIMEOUT`. A late `adder_done` has no effect on the next operation beyond the `SETTLE` rule.

## Test plan
- Single add, WIDTH=8: a=0x25, b=0x17, `out_ready`=1 → `out_sum`=0x3C, `out_err`=0, `out_valid` at T+6, `adder_start` high exactly 4 cycles.
- Wrap: a=0xFF, b=0x01 → `out_sum`=0x00, `out_err`=0; then a=0x80, b=0x80 → 0x00.
- Back-pressure: 3 pairs pushed with `out_ready`=0 → `in_ready`=0 after 2 buffered plus 1 in flight. First result holds stable until `out_ready`=1. Results come out in order (0x03, 0x07, 0x0B for 1+2, 3+4, 5+6).
- Timeout: `adder_done` forced 0 → `out_valid` at T+19 with `out_err`=1, `out_sum`=0. The next pair completes normally.
- Reset mid-WAIT: `rst` pulsed 1 cycle → next cycle `adder_start`=0, `out_valid`=0, `in_ready`=1. No result is produced for the flushed pairs.
- Simultaneous push/pop at occupancy 1 → occupancy stays 1, no loss or duplication, checked across 20 random pairs against a reference model.
